bcd_counter_rtl: RTL and testbench

BCD_COUNTER_RTL -- requirements
Module: bcd_counter_rtl

---
 rtl/bcd_counter_rtl.sv | 65 ++++++
 tb/tb_bcd_counter_rtl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_rtl.sv
// Two-digit free-running BCD counter that wraps from LIMIT back to 00.
// Any out-of-range digit or count reloads 00 on the next edge.
module bcd_counter_rtl #(
    parameter int unsigned LIMIT = 99
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       tc
);

    localparam int unsigned DW  = 4;
    localparam int unsigned CW  = 8;
    localparam logic [DW-1:0] LIM_T = DW'(LIMIT / 10);
    localparam logic [DW-1:0] LIM_U = DW'(LIMIT % 10);
    localparam logic [CW-1:0] LIM_V = CW'(LIMIT);

    // A terminal count outside 1..99 cannot be represented by two BCD digits
    if (LIMIT == 0 || LIMIT > 99) begin : g_bad_limit
        $error("bcd_counter_rtl: LIMIT must be in 1..99");
    end

    logic [DW-1:0] tens_q;
    logic [DW-1:0] units_q;
    logic [DW-1:0] tens_d;
    logic [DW-1:0] units_d;
    logic [CW-1:0] count_val;
    logic          illegal;

    assign tens  = tens_q;
    assign units = units_q;

    // Terminal count decoded straight from the digit registers
    assign tc = (tens_q == LIM_T) && (units_q == LIM_U);

    // Next-count logic: wrap at LIMIT, carry on units 9, recover from illegal states
    always_comb begin
        tens_d    = tens_q;
        units_d   = units_q;
        count_val = CW'(tens_q) * CW'(10) + CW'(units_q);
        illegal   = (tens_q > DW'(9)) || (units_q > DW'(9)) || (count_val > LIM_V);
        if (illegal || tc) begin
            tens_d  = '0;
            units_d = '0;
        end else if (units_q == DW'(9)) begin
            tens_d  = tens_q + DW'(1);
            units_d = '0;
        end else begin
            units_d = units_q + DW'(1);
        end
    end

    // Digit registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: tb/tb_bcd_counter_rtl.sv
// Directed bench for bcd_counter_rtl: default LIMIT and LIMIT=23 side by side.
module tb_bcd_counter_rtl;

    logic       clk;
    logic       rst;
    logic [3:0] tens_a;
    logic [3:0] units_a;
    logic       tc_a;
    logic [3:0] tens_b;
    logic [3:0] units_b;
    logic       tc_b;

    int n_vec;
    int n_err;
    int tc_hits;
    int exp_a;
    int exp_b;
    bit bcd_chk;

    bcd_counter_rtl dut_a (
        .clk   (clk),
        .rst   (rst),
        .tens  (tens_a),
        .units (units_a),
        .tc    (tc_a)
    );

    bcd_counter_rtl #(.LIMIT(23)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .tens  (tens_b),
        .units (units_b),
        .tc    (tc_b)
    );

    // 10 ns clock, first rising edge at 5 ns
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cnt(input logic [3:0] t, input logic [3:0] u);
        return 10 * int'(t) + int'(u);
    endfunction

    // Digits must always be BCD outside the deliberate corruption steps
    always @(negedge clk) begin
        if (bcd_chk && rst) begin
            check("bcd_a_tens", int'(tens_a > 4'd9), 0);
            check("bcd_a_units", int'(units_a > 4'd9), 0);
            check("bcd_b_tens", int'(tens_b > 4'd9), 0);
            check("bcd_b_units", int'(units_b > 4'd9), 0);
        end
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        tc_hits = 0;
        bcd_chk = 1'b0;
        rst     = 1'b0;

        // Reset is immediate and holds across a clock edge
        #2;
        check("rst_a_count", cnt(tens_a, units_a), 0);
        check("rst_a_tc", int'(tc_a), 0);
        check("rst_b_count", cnt(tens_b, units_b), 0);
        #5;
        check("rst_hold_a", cnt(tens_a, units_a), 0);
        check("rst_hold_b", cnt(tens_b, units_b), 0);

        // Release at 10 ns; 200 edges cover two full default wrap periods
        #3;
        rst     = 1'b1;
        bcd_chk = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            exp_a = n % 100;
            exp_b = n % 24;
            check("run_a_count", cnt(tens_a, units_a), exp_a);
            check("run_a_tc", int'(tc_a), int'(exp_a == 99));
            check("run_b_count", cnt(tens_b, units_b), exp_b);
            check("run_b_tc", int'(tc_b), int'(exp_b == 23));
            if (tc_a) tc_hits++;
            if (n == 20 || n == 120) begin
                check("carry19_tens", int'(tens_a), 2);
                check("carry19_units", int'(units_a), 0);
            end
            if (n == 30) begin
                check("carry29_tens", int'(tens_a), 3);
                check("carry29_units", int'(units_a), 0);
            end
        end
        check("tc_hits_a", tc_hits, 2);

        // Advance dut_a from 00 to 57, then reset between edges
        repeat (57) @(posedge clk);
        #1;
        check("pre_rst_57", cnt(tens_a, units_a), 57);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_a", cnt(tens_a, units_a), 0);
        check("async_rst_b", cnt(tens_b, units_b), 0);
        check("async_rst_tc", int'(tc_a), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stay_a", cnt(tens_a, units_a), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("restart_a", cnt(tens_a, units_a), 1);
        check("restart_b", cnt(tens_b, units_b), 1);

        // Corrupt dut_a units to C and dut_b to 50 (> LIMIT); next edge reloads 00
        @(negedge clk);
        bcd_chk = 1'b0;
        force dut_a.units_q = 4'hC;
        force dut_b.tens_q  = 4'd5;
        force dut_b.units_q = 4'd0;
        #1;
        release dut_a.units_q;
        release dut_b.tens_q;
        release dut_b.units_q;
        check("forced_a_units", int'(units_a), 12);
        @(posedge clk);
        #1;
        check("recover_a", cnt(tens_a, units_a), 0);
        check("recover_b", cnt(tens_b, units_b), 0);
        bcd_chk = 1'b1;
        @(posedge clk);
        #1;
        check("post_recover_a", cnt(tens_a, units_a), 1);
        check("post_recover_b", cnt(tens_b, units_b), 1);

        // Reset asserted on the wrap cycle of dut_b (count 23)
        repeat (22) @(posedge clk);
        #1;
        check("b_at_23", cnt(tens_b, units_b), 23);
        check("b_tc_23", int'(tc_b), 1);
        rst = 1'b0;
        #1;
        check("b_rst_at_wrap", cnt(tens_b, units_b), 0);
        check("b_tc_rst", int'(tc_b), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("after_rst_a_10", cnt(tens_a, units_a), 10);
        check("after_rst_b_10", cnt(tens_b, units_b), 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
